// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
//
// Serial receiver for parity-protected frames. A frame is one start bit (0),
// DATA_BITS data bits sent MSB first, one parity bit and one stop bit (1).
// The receiver recomputes the XOR parity over the data bits, compares it with
// the received parity bit, and reports the payload plus parity and framing
// status. Saturating counters track good and bad frames for debug readout.
//
// Parameters:
//   DATA_BITS   data bits per frame (2..16)
//   ODD_PARITY  0 = even parity, 1 = odd parity
//   CNT_W       width of the good / error frame counters
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   bit_en       qualifies serial_in; the FSM only advances when high
//   serial_in    serial line, idles high
//   data_out     payload of the last frame with a correct stop bit
//   frame_valid  one-cycle pulse when a frame with a good stop bit completes
//   parity_err   one-cycle pulse with frame_valid when parity mismatches
//   frame_err    one-cycle pulse when the stop bit is sampled as 0
//   busy         high whenever the receiver is not idle
//   good_cnt     count of error-free frames, saturating
//   err_cnt      count of parity or framing errors, saturating
// ---------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int DATA_BITS  = 4,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     good_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 exp_par;
    logic                 par_bad;

    // Parity the sender should have produced for the shifted-in payload.
    assign exp_par = (^shift_q) ^ ODD_BIT;
    assign par_bad = (rx_par_q != exp_par);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        rx_par_d      = rx_par_q;
        data_out_d    = data_out_q;
        good_cnt_d    = good_cnt_q;
        err_cnt_d     = err_cnt_q;
        frame_valid_d = 1'b0;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {shift_q[DATA_BITS-2:0], serial_in};
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                PARITY: begin
                    rx_par_d = serial_in;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (serial_in) begin
                        frame_valid_d = 1'b1;
                        data_out_d    = shift_q;
                        parity_err_d  = par_bad;
                        if (par_bad) begin
                            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                        end else begin
                            if (good_cnt_q != CNT_MAX) good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else begin
                        // Broken stop bit: payload and parity are untrusted.
                        frame_err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered busy reflects the state being entered.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_par_q      <= 1'b0;
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            good_cnt_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_par_q      <= rx_par_d;
            data_out_q    <= data_out_d;
            frame_valid_q <= frame_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign frame_valid = frame_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign good_cnt    = good_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_rx
//
// Self-checking bench for parity_frame_rx. Three receivers share clock and
// reset: inst 0 is the default build, inst 1 has 2-bit counters, inst 2 uses
// odd parity. Each frame pushes its predicted outcome onto a scoreboard; the
// entry is popped and compared in the cycle the pulse must be visible.
// ---------------------------------------------------------------------------
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] bit_en_v = 3'b000;
    logic [2:0] serial_v = 3'b111;

    logic [3:0] data_out0, data_out1, data_out2;
    logic       fv0, fv1, fv2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       busy0, busy1, busy2;
    logic [7:0] good0, err0, good2, err2;
    logic [1:0] good1, err1;

    int test_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        int         inst;
        logic [3:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
        int         good;
        int         err;
    } exp_t;

    exp_t sb[$];

    int         m_good[3];
    int         m_err[3];
    logic [3:0] m_data[3];
    int         m_max[3] = '{255, 3, 255};
    logic       m_odd[3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_BITS(4), .ODD_PARITY(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .bit_en(bit_en_v[0]), .serial_in(serial_v[0]),
        .data_out(data_out0), .frame_valid(fv0), .parity_err(pe0),
        .frame_err(fe0), .busy(busy0), .good_cnt(good0), .err_cnt(err0)
    );

    parity_frame_rx #(.DATA_BITS(4), .ODD_PARITY(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bit_en(bit_en_v[1]), .serial_in(serial_v[1]),
        .data_out(data_out1), .frame_valid(fv1), .parity_err(pe1),
        .frame_err(fe1), .busy(busy1), .good_cnt(good1), .err_cnt(err1)
    );

    parity_frame_rx #(.DATA_BITS(4), .ODD_PARITY(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .bit_en(bit_en_v[2]), .serial_in(serial_v[2]),
        .data_out(data_out2), .frame_valid(fv2), .parity_err(pe2),
        .frame_err(fe2), .busy(busy2), .good_cnt(good2), .err_cnt(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        test_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic getOut(input int inst, output logic [31:0] dout, output logic [31:0] fv,
                          output logic [31:0] pe, output logic [31:0] fe,
                          output logic [31:0] bz, output logic [31:0] gc,
                          output logic [31:0] ec);
        case (inst)
            0: begin
                dout = 32'(data_out0); fv = 32'(fv0); pe = 32'(pe0); fe = 32'(fe0);
                bz = 32'(busy0); gc = 32'(good0); ec = 32'(err0);
            end
            1: begin
                dout = 32'(data_out1); fv = 32'(fv1); pe = 32'(pe1); fe = 32'(fe1);
                bz = 32'(busy1); gc = 32'(good1); ec = 32'(err1);
            end
            default: begin
                dout = 32'(data_out2); fv = 32'(fv2); pe = 32'(pe2); fe = 32'(fe2);
                bz = 32'(busy2); gc = 32'(good2); ec = 32'(err2);
            end
        endcase
    endtask

    task automatic driveBit(input int inst, input logic b, input logic en);
        bit_en_v         = 3'b000;
        serial_v         = 3'b111;
        bit_en_v[inst]   = en;
        serial_v[inst]   = b;
    endtask

    task automatic applyStimulus(input int inst, input logic b, input logic en);
        @(negedge clk);
        driveBit(inst, b, en);
    endtask

    // Pops the scoreboard in the cycle after the stop-bit edge, then checks
    // that the pulses are gone one cycle later.
    task automatic checkOutput();
        exp_t e;
        logic [31:0] dout, fv, pe, fe, bz, gc, ec;
        @(negedge clk);
        driveBit(0, 1'b1, 1'b0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        getOut(e.inst, dout, fv, pe, fe, bz, gc, ec);
        check("frame_valid", fv, 32'(e.valid));
        check("parity_err", pe, 32'(e.perr));
        check("frame_err", fe, 32'(e.ferr));
        check("data_out", dout, 32'(e.data));
        check("good_cnt", gc, 32'(e.good));
        check("err_cnt", ec, 32'(e.err));
        check("busy_after_stop", bz, 32'd0);
        @(negedge clk);
        getOut(e.inst, dout, fv, pe, fe, bz, gc, ec);
        check("valid_drop", fv, 32'd0);
        check("perr_drop", pe, 32'd0);
        check("ferr_drop", fe, 32'd0);
    endtask

    task automatic sendFrame(input int inst, input logic [3:0] data, input logic par,
                             input logic stop, input logic toggle);
        exp_t        e;
        logic        exp_par;
        logic [31:0] dout, fv, pe, fe, bz, gc, ec;
        logic [5:0]  bits;
        bits = {1'b0, data, par};
        for (int i = 5; i >= 0; i--) begin
            applyStimulus(inst, bits[i], 1'b1);
            if (toggle) applyStimulus(inst, ~bits[i], 1'b0);
        end
        // Stop bit not yet sampled: still busy, no pulse yet.
        @(negedge clk);
        getOut(inst, dout, fv, pe, fe, bz, gc, ec);
        check("busy_before_stop", bz, 32'd1);
        check("no_early_valid", fv, 32'd0);
        driveBit(inst, stop, 1'b1);

        exp_par = (^data) ^ m_odd[inst];
        e.inst  = inst;
        if (stop) begin
            e.valid = 1'b1;
            e.ferr  = 1'b0;
            e.perr  = (par != exp_par);
            m_data[inst] = data;
            if (e.perr) begin
                if (m_err[inst] < m_max[inst]) m_err[inst]++;
            end else begin
                if (m_good[inst] < m_max[inst]) m_good[inst]++;
            end
        end else begin
            e.valid = 1'b0;
            e.ferr  = 1'b1;
            e.perr  = 1'b0;
            if (m_err[inst] < m_max[inst]) m_err[inst]++;
        end
        e.data = m_data[inst];
        e.good = m_good[inst];
        e.err  = m_err[inst];
        sb.push_back(e);
        checkOutput();
    endtask

    task automatic resetModels();
        for (int i = 0; i < 3; i++) begin
            m_good[i] = 0;
            m_err[i]  = 0;
            m_data[i] = 4'h0;
        end
    endtask

    initial begin
        logic [31:0] dout, fv, pe, fe, bz, gc, ec;
        resetModels();

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        getOut(0, dout, fv, pe, fe, bz, gc, ec);
        check("rst_data", dout, 32'd0);
        check("rst_valid", fv, 32'd0);
        check("rst_busy", bz, 32'd0);
        check("rst_good", gc, 32'd0);
        check("rst_err", ec, 32'd0);

        // Good frame, parity error, framing error, enable-gapped frame
        sendFrame(0, 4'b1011, 1'b1, 1'b1, 1'b0);
        sendFrame(0, 4'b0110, 1'b1, 1'b1, 1'b0);
        sendFrame(0, 4'b1111, 1'b0, 1'b0, 1'b0);
        sendFrame(0, 4'b1011, 1'b1, 1'b1, 1'b1);

        // Idle line for 20 cycles: nothing happens
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1'b1, 1'b1);
            getOut(0, dout, fv, pe, fe, bz, gc, ec);
            check("idle_valid", fv, 32'd0);
            check("idle_ferr", fe, 32'd0);
            check("idle_busy", bz, 32'd0);
        end

        // Reset in the middle of a frame
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        @(negedge clk);
        driveBit(0, 1'b1, 1'b0);
        rst = 1'b0;
        resetModels();
        @(negedge clk);
        getOut(0, dout, fv, pe, fe, bz, gc, ec);
        check("midrst_data", dout, 32'd0);
        check("midrst_valid", fv, 32'd0);
        check("midrst_busy", bz, 32'd0);
        check("midrst_good", gc, 32'd0);
        check("midrst_err", ec, 32'd0);
        @(negedge clk);
        getOut(0, dout, fv, pe, fe, bz, gc, ec);
        check("midrst_valid2", fv, 32'd0);
        rst = 1'b1;
        sendFrame(0, 4'b0011, 1'b0, 1'b1, 1'b0);

        // 2-bit counters saturate at 3
        for (int i = 0; i < 5; i++) sendFrame(1, 4'b0110, 1'b1, 1'b1, 1'b0);

        // Odd parity build accepts parity 0 for 1011
        sendFrame(2, 4'b1011, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
